// File: rtl/seq_det_scheduler.sv
// Round-robin arbiter that time-shares one serial "1010" detector among NUM_REQ
// word requesters, returning a per-job overlapping-match count tagged with the id.
module seq_det_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DET_LAT = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       det_resetn,
    output logic                       det_din,
    input  logic                       det_dout,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic [$clog2(WIDTH+1)-1:0] res_count,
    output logic                       res_hit
);
    localparam int IDW        = $clog2(NUM_REQ);
    localparam int CW         = $clog2(WIDTH + 1);
    localparam int SW         = $clog2(((WIDTH > DET_LAT) ? WIDTH : DET_LAT) + 1);
    localparam int DRAIN_LAST = (DET_LAT > 0) ? DET_LAT - 1 : 0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        RESULT
    } state_t;

    state_t           state;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   job_id;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   cand;
    logic             gnt_found;
    logic [WIDTH-1:0] gnt_word;
    logic [WIDTH-1:0] word;
    logic [SW-1:0]    step_cnt;
    logic [CW-1:0]    match_cnt;
    logic [CW-1:0]    match_next;

    // First pending requester after the last winner, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (32'(last) + k >= NUM_REQ)
                cand = IDW'(32'(last) + k - NUM_REQ);
            else
                cand = IDW'(32'(last) + k);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    always_comb begin
        gnt_word = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == gnt_id)
                gnt_word = req_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        req_ready = '0;
        if (resetn && state == IDLE && gnt_found)
            req_ready[gnt_id] = 1'b1;
    end

    assign match_next = match_cnt + CW'(det_dout);

    // Detector outputs are loaded one edge early so they line up with the state they belong to.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last       <= IDW'(NUM_REQ - 1);
            job_id     <= '0;
            word       <= '0;
            step_cnt   <= '0;
            match_cnt  <= '0;
            det_resetn <= 1'b0;
            det_din    <= 1'b0;
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_count  <= '0;
            res_hit    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    det_din <= 1'b0;
                    if (gnt_found) begin
                        job_id     <= gnt_id;
                        last       <= gnt_id;
                        word       <= gnt_word;
                        det_resetn <= 1'b0;
                        state      <= CLEAR;
                    end else begin
                        det_resetn <= 1'b1;
                    end
                end
                CLEAR: begin
                    det_resetn <= 1'b1;
                    det_din    <= word[WIDTH-1];
                    word       <= word << 1;
                    step_cnt   <= SW'(WIDTH - 1);
                    match_cnt  <= '0;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    match_cnt <= match_next;
                    if (step_cnt != '0) begin
                        det_din  <= word[WIDTH-1];
                        word     <= word << 1;
                        step_cnt <= step_cnt - 1'b1;
                    end else if (DET_LAT > 0) begin
                        det_din  <= 1'b0;
                        step_cnt <= SW'(DRAIN_LAST);
                        state    <= DRAIN;
                    end else begin
                        det_din   <= 1'b0;
                        res_valid <= 1'b1;
                        res_id    <= job_id;
                        res_count <= match_next;
                        res_hit   <= (match_next != '0);
                        state     <= RESULT;
                    end
                end
                DRAIN: begin
                    match_cnt <= match_next;
                    if (step_cnt != '0) begin
                        step_cnt <= step_cnt - 1'b1;
                    end else begin
                        res_valid <= 1'b1;
                        res_id    <= job_id;
                        res_count <= match_next;
                        res_hit   <= (match_next != '0);
                        state     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
